aes_round_key_gen: RTL and testbench

//  Iterative AES-128 key schedule. Produces one 128-bit round key per advance request.

---
 rtl/aes_round_key_gen.sv | 193 +++++++++++++++++++
 tb/tb_aes_round_key_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_gen.sv
// -----------------------------------------------------------------------------
// aes_round_key_gen
//   Iterative AES-128 key schedule. The current round key is held in a register
//   and the next one is derived from it on each advance request, so the full
//   11-key schedule is never stored.
//
// Ports
//   clk        in   1    system clock, rising edge
//   rst        in   1    asynchronous reset, active-high
//   load       in   1    capture key_in as round key 0 (wins over advance)
//   key_in     in   128  cipher key, byte 0 in [127:120]
//   advance    in   1    step to next round key; ignored unless key_valid
//   round_key  out  128  current round key (registered)
//   round_idx  out  4    index of round_key, 0..10
//   key_valid  out  1    round_key/round_idx are meaningful
//   done       out  1    one-cycle pulse when the round 10 key is consumed
//
// Also contains aes_sbox, the combinational AES S-box used by SubWord.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// aes_sbox
//   Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
//   FIPS-197 affine transform.
// Ports
//   in_i   in   8   input byte
//   out_o  out  8   substituted byte
// -----------------------------------------------------------------------------
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] sq;
   logic [7:0] inv;

   // inv = x^254 = x^(2+4+...+128); this also maps 0 to 0 as the S-box requires.
   always_comb begin
      sq  = in_i;
      inv = 8'h01;
      for (int unsigned i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      out_o = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
   end

endmodule

module aes_round_key_gen #(
   parameter int NR    = 10,
   parameter int KEY_W = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [KEY_W-1:0] key_in,
   input  logic             advance,
   output logic [KEY_W-1:0] round_key,
   output logic [3:0]       round_idx,
   output logic             key_valid,
   output logic             done
);

   if (NR != 10 || KEY_W != 128) begin : g_bad_param
      $error("aes_round_key_gen supports only AES-128 (NR=10, KEY_W=128)");
   end

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   state_t             state_q, state_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [3:0]         idx_q, idx_d;
   logic [7:0]         rcon_q, rcon_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;

   // ---------------- next-key datapath ----------------
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot_w3, sub_w3, t_w;
   logic [31:0] n0, n1, n2, n3;
   logic [KEY_W-1:0] next_key;
   logic [7:0]  rcon_next;

   assign w0 = key_q[127:96];
   assign w1 = key_q[95:64];
   assign w2 = key_q[63:32];
   assign w3 = key_q[31:0];

   assign rot_w3 = {w3[23:0], w3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .in_i  (rot_w3[8*g +: 8]),
         .out_o (sub_w3[8*g +: 8])
      );
   end

   assign t_w = sub_w3 ^ {rcon_q, 24'h000000};
   assign n0  = w0 ^ t_w;
   assign n1  = w1 ^ n0;
   assign n2  = w2 ^ n1;
   assign n3  = w3 ^ n2;
   assign next_key  = {n0, n1, n2, n3};
   assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         idx_q   <= '0;
         rcon_q  <= 8'h01;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         rcon_q  <= rcon_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      rcon_d  = rcon_q;
      valid_d = valid_q;
      done_d  = 1'b0;

      if (load) begin
         state_d = ACTIVE;
         key_d   = key_in;
         idx_d   = '0;
         rcon_d  = 8'h01;
         valid_d = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               valid_d = 1'b0;
            end
            ACTIVE: begin
               if (advance) begin
                  if (idx_q == 4'(NR)) begin
                     // Final key consumed: key and index hold for inspection.
                     state_d = IDLE;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     key_d  = next_key;
                     idx_d  = idx_q + 4'd1;
                     rcon_d = rcon_next;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   assign round_key = key_q;
   assign round_idx = idx_q;
   assign key_valid = valid_q;
   assign done      = done_q;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// -----------------------------------------------------------------------------
// tb_aes_round_key_gen
//   Directed plus randomized checks of aes_round_key_gen against a word-level
//   FIPS-197 key expansion model with a table-built S-box.
// -----------------------------------------------------------------------------
module tb_aes_round_key_gen;

   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic [127:0] key_in;
   logic         advance;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         done;

   always #5 clk = ~clk;

   aes_round_key_gen #(.NR(10), .KEY_W(128)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .key_in    (key_in),
      .advance   (advance),
      .round_key (round_key),
      .round_idx (round_idx),
      .key_valid (key_valid),
      .done      (done)
   );

   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;
   int unsigned fail_cnt  = 0;

   // ---------------- reference model ----------------
   logic [7:0]   sb [256];
   logic [127:0] rk [11];
   logic [7:0]   rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   // Walk generator 3 and its inverse together to fill the S-box table.
   task automatic build_sbox();
      logic [7:0] p, q;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
   endtask

   task automatic expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4-1], 24'h0};
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KA1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] KA2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] KA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KZ1  = 128'h62636363626363636263636362636363;

   initial begin
      logic [127:0] kr;
      int unsigned  gap;

      build_sbox();
      rst = 1'b1; load = 1'b0; advance = 1'b0; key_in = '0;
      repeat (2) tick();
      chk("rst_key",   round_key, '0);
      chk("rst_idx",   128'(round_idx), '0);
      chk("rst_valid", 128'(key_valid), '0);
      chk("rst_done",  128'(done), '0);
      rst = 1'b0;
      tick();

      // FIPS-197 A.1 first round
      expand(KA);
      load = 1'b1; key_in = KA; tick(); load = 1'b0;
      chk("load_key",   round_key, rk[0]);
      chk("load_idx",   128'(round_idx), 128'd0);
      chk("load_valid", 128'(key_valid), 128'd1);
      advance = 1'b1; tick(); advance = 1'b0;
      chk("a1_r1_const", round_key, KA1);
      chk("a1_r1_idx",   128'(round_idx), 128'd1);

      // back-to-back advances
      load = 1'b1; tick(); load = 1'b0;
      advance = 1'b1;
      for (int r = 1; r <= 10; r++) begin
         tick();
         chk($sformatf("b2b_key_r%0d", r), round_key, rk[r]);
         chk($sformatf("b2b_idx_r%0d", r), 128'(round_idx), 128'(r));
         chk($sformatf("b2b_done_r%0d", r), 128'(done), 128'd0);
         if (r == 2)  chk("b2b_r2_const", round_key, KA2);
         if (r == 10) chk("b2b_r10_const", round_key, KA10);
      end
      tick(); advance = 1'b0;
      chk("final_done",  128'(done), 128'd1);
      chk("final_valid", 128'(key_valid), 128'd0);
      chk("final_key",   round_key, rk[10]);
      chk("final_idx",   128'(round_idx), 128'd10);
      tick();
      chk("done_pulse_end", 128'(done), 128'd0);
      advance = 1'b1; tick(); advance = 1'b0;
      chk("idle_adv_key",   round_key, rk[10]);
      chk("idle_adv_valid", 128'(key_valid), 128'd0);

      // gapped advances
      load = 1'b1; tick(); load = 1'b0;
      for (int r = 1; r <= 10; r++) begin
         gap = $urandom_range(0, 5);
         repeat (gap) begin
            tick();
            chk($sformatf("gap_hold_r%0d", r - 1), round_key, rk[r-1]);
         end
         advance = 1'b1; tick(); advance = 1'b0;
         chk($sformatf("gap_key_r%0d", r), round_key, rk[r]);
      end

      // random keys through the full schedule
      repeat (4) begin
         kr = {$urandom, $urandom, $urandom, $urandom};
         expand(kr);
         load = 1'b1; key_in = kr; tick(); load = 1'b0;
         chk("rnd_key_r0", round_key, rk[0]);
         advance = 1'b1;
         for (int r = 1; r <= 10; r++) begin
            tick();
            chk($sformatf("rnd_key_r%0d", r), round_key, rk[r]);
         end
         tick(); advance = 1'b0;
         chk("rnd_done", 128'(done), 128'd1);
      end

      // reload zero key mid-schedule
      expand(KA);
      load = 1'b1; key_in = KA; tick(); load = 1'b0;
      advance = 1'b1; repeat (4) tick(); advance = 1'b0;
      chk("pre_reload_idx", 128'(round_idx), 128'd4);
      load = 1'b1; key_in = '0; tick(); load = 1'b0;
      chk("reload_idx",   128'(round_idx), 128'd0);
      chk("reload_key",   round_key, '0);
      chk("reload_done",  128'(done), 128'd0);
      chk("reload_valid", 128'(key_valid), 128'd1);
      expand('0);
      advance = 1'b1; tick(); advance = 1'b0;
      chk("zero_r1_const", round_key, KZ1);
      chk("zero_r1_model", round_key, rk[1]);

      // async reset off the clock edge at round 6
      expand(KA);
      load = 1'b1; key_in = KA; tick(); load = 1'b0;
      advance = 1'b1; repeat (6) tick(); advance = 1'b0;
      chk("pre_rst_key", round_key, rk[6]);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_key",   round_key, '0);
      chk("async_rst_idx",   128'(round_idx), '0);
      chk("async_rst_valid", 128'(key_valid), '0);
      chk("async_rst_done",  128'(done), '0);
      tick(); rst = 1'b0;
      advance = 1'b1;
      repeat (3) begin
         tick();
         chk("post_rst_valid", 128'(key_valid), '0);
         chk("post_rst_idx",   128'(round_idx), '0);
         chk("post_rst_key",   round_key, '0);
      end
      advance = 1'b0;

      // load and advance together while active
      load = 1'b1; key_in = KA; tick(); load = 1'b0;
      advance = 1'b1; repeat (3) tick();
      kr = {$urandom, $urandom, $urandom, $urandom};
      load = 1'b1; key_in = kr; tick(); load = 1'b0; advance = 1'b0;
      chk("ld_adv_idx",   128'(round_idx), 128'd0);
      chk("ld_adv_key",   round_key, kr);
      chk("ld_adv_done",  128'(done), 128'd0);
      chk("ld_adv_valid", 128'(key_valid), 128'd1);
      expand(kr);
      advance = 1'b1; tick(); advance = 1'b0;
      chk("ld_adv_r1", round_key, rk[1]);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
